// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Program-counter owner and single-outstanding instruction
//                fetcher for the single-issue MIPS core. Resolves beq/bne
//                next-PC selection at decode accept and halts on a
//                misaligned fetch target.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [5:0]  opcode_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        branch_eq_i,
    input  logic        branch_ne_i,
    input  logic        zero_i,
    input  logic [31:0] branch_target_i,
    output logic        fault_o,
    output logic [31:0] retired_count_o
);

    localparam logic [1:0] c_st_rst   = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_halt  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;

    logic [31:0] w_pc_plus4;
    logic        w_taken;
    logic [31:0] w_next_pc;

    // Sequential PC wraps naturally at 2^32; branch inputs only matter when
    // the HOLD state accepts, so they are evaluated unconditionally here.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_taken    = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
    assign w_next_pc  = w_taken ? branch_target_i : w_pc_plus4;

    // Fetch FSM: request, hold for decode, then advance or halt on fault
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_rst;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_count <= 32'd0;
        end else begin
            case (r_state)
                c_st_rst: begin
                    r_state <= c_st_fetch;
                end
                c_st_fetch: begin
                    if (imem_ack_i) begin
                        r_instr <= imem_rdata_i;
                        r_state <= c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (instr_ready_i) begin
                        r_pc    <= w_next_pc;
                        r_count <= r_count + 32'd1;
                        // A misaligned target is parked in the PC for
                        // debug visibility and fetch stops until reset.
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_state <= c_st_halt;
                        end else begin
                            r_state <= c_st_fetch;
                        end
                    end
                end
                c_st_halt: begin
                    r_state <= c_st_halt;
                end
                default: begin
                    r_state <= c_st_rst;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state
    assign imem_req_o      = (r_state == c_st_fetch);
    assign imem_addr_o     = r_pc;
    assign instr_valid_o   = (r_state == c_st_hold);
    assign instr_o         = r_instr;
    assign opcode_o        = r_instr[31:26];
    assign pc_o            = r_pc;
    assign pc_plus4_o      = w_pc_plus4;
    assign fault_o         = (r_state == c_st_halt);
    assign retired_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Directed table-driven bench for instruction_fetch with
//                hand-written branch, wrap and reset-during-ack sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] c_reset_pc = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [5:0]  opcode_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        branch_eq_i;
    logic        branch_ne_i;
    logic        zero_i;
    logic [31:0] branch_target_i;
    logic        fault_o;
    logic [31:0] retired_count_o;

    int errors = 0;
    int checks = 0;

    instruction_fetch #(
        .RESET_PC (c_reset_pc)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .opcode_o        (opcode_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .branch_eq_i     (branch_eq_i),
        .branch_ne_i     (branch_ne_i),
        .zero_i          (zero_i),
        .branch_target_i (branch_target_i),
        .fault_o         (fault_o),
        .retired_count_o (retired_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        beq;
        logic        bne;
        logic        z;
        logic [31:0] tgt;
        logic        e_req;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(
        input logic rst, input logic ack, input logic [31:0] rdata,
        input logic rdy, input logic beq, input logic bne, input logic z,
        input logic [31:0] tgt,
        input logic e_req, input logic e_valid, input logic e_fault,
        input logic [31:0] e_addr, input logic [31:0] e_instr,
        input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.beq = beq; v.bne = bne; v.z = z; v.tgt = tgt;
        v.e_req = e_req; v.e_valid = e_valid; v.e_fault = e_fault;
        v.e_addr = e_addr; v.e_instr = e_instr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'd0;
        instr_ready_i   = 1'b0;
        branch_eq_i     = 1'b0;
        branch_ne_i     = 1'b0;
        zero_i          = 1'b0;
        branch_target_i = 32'd0;
    endtask

    // Leaves the DUT in FETCH at RESET_PC, sampled just after an edge.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check its address, ack it, then accept
    // the instruction with the given branch inputs.
    task automatic fetch_one(input string name, input logic [31:0] exp_addr,
                             input logic [31:0] word, input logic beq,
                             input logic bne, input logic z,
                             input logic [31:0] tgt);
        int n;
        n = 0;
        while (!imem_req_o && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({name, "_req"}, {31'd0, imem_req_o}, 32'd1);
        chk({name, "_addr"}, imem_addr_o, exp_addr);
        imem_ack_i   = 1'b1;
        imem_rdata_i = word;
        @(posedge clk);
        #1 idle_inputs();
        chk({name, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
        instr_ready_i   = 1'b1;
        branch_eq_i     = beq;
        branch_ne_i     = bne;
        zero_i          = z;
        branch_target_i = tgt;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic branch_case(input string name, input logic beq,
                               input logic bne, input logic z,
                               input logic [31:0] exp_next);
        do_reset();
        fetch_one({name, "_f0"}, 32'h0040_0000, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'd0);
        fetch_one({name, "_f1"}, 32'h0040_0004, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'd0);
        fetch_one({name, "_br"}, 32'h0040_0008, 32'h1000_0005, beq, bne, z, 32'h0040_0020);
        chk({name, "_next_req"}, {31'd0, imem_req_o}, 32'd1);
        chk({name, "_next_addr"}, imem_addr_o, exp_next);
        chk({name, "_fault"}, {31'd0, fault_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //           rst ack rdata          rdy beq bne z  tgt           req val flt addr           instr          cnt
        vecs[0]  = mk(0, 1, 32'hAAAA_AAAA, 0, 0, 0, 0, 32'd0,          0, 0, 0, 32'h0040_0000, 32'h0000_0000, 32'd0);
        vecs[1]  = mk(0, 1, 32'h2008_0005, 0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0000, 32'h0000_0000, 32'd0);
        vecs[2]  = mk(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'd0,          0, 1, 0, 32'h0040_0000, 32'h2008_0005, 32'd0);
        vecs[3]  = mk(0, 0, 32'd0,         1, 0, 0, 0, 32'd0,          0, 1, 0, 32'h0040_0000, 32'h2008_0005, 32'd0);
        vecs[4]  = mk(0, 1, 32'h0000_0020, 0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0004, 32'h2008_0005, 32'd1);
        vecs[5]  = mk(0, 0, 32'd0,         1, 0, 0, 0, 32'd0,          0, 1, 0, 32'h0040_0004, 32'h0000_0020, 32'd1);
        vecs[6]  = mk(0, 0, 32'd0,         0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0008, 32'h0000_0020, 32'd2);
        vecs[7]  = mk(0, 0, 32'd0,         0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0008, 32'h0000_0020, 32'd2);
        vecs[8]  = mk(0, 0, 32'd0,         0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0008, 32'h0000_0020, 32'd2);
        vecs[9]  = mk(0, 1, 32'h1000_0004, 0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0008, 32'h0000_0020, 32'd2);
        vecs[10] = mk(0, 0, 32'd0,         0, 1, 0, 1, 32'h0040_0020, 0, 1, 0, 32'h0040_0008, 32'h1000_0004, 32'd2);
        vecs[11] = mk(0, 0, 32'd0,         0, 1, 0, 1, 32'h0040_0020, 0, 1, 0, 32'h0040_0008, 32'h1000_0004, 32'd2);
        vecs[12] = mk(0, 0, 32'd0,         0, 1, 0, 1, 32'h0040_0020, 0, 1, 0, 32'h0040_0008, 32'h1000_0004, 32'd2);
        vecs[13] = mk(0, 0, 32'd0,         0, 1, 0, 1, 32'h0040_0020, 0, 1, 0, 32'h0040_0008, 32'h1000_0004, 32'd2);
        vecs[14] = mk(0, 0, 32'd0,         1, 1, 0, 0, 32'h0040_0020, 0, 1, 0, 32'h0040_0008, 32'h1000_0004, 32'd2);
        vecs[15] = mk(0, 1, 32'h1400_0004, 0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_000C, 32'h1000_0004, 32'd3);
        vecs[16] = mk(0, 0, 32'd0,         1, 0, 1, 0, 32'h0040_0020, 0, 1, 0, 32'h0040_000C, 32'h1400_0004, 32'd3);
        vecs[17] = mk(0, 1, 32'h1000_0002, 0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0020, 32'h1400_0004, 32'd4);
        vecs[18] = mk(0, 0, 32'd0,         1, 1, 0, 1, 32'h0040_0022, 0, 1, 0, 32'h0040_0020, 32'h1000_0002, 32'd4);
        vecs[19] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'd0,          0, 0, 1, 32'h0040_0022, 32'h1000_0002, 32'd5);
        vecs[20] = mk(0, 1, 32'hDEAD_BEEF, 1, 1, 0, 1, 32'h0040_0040, 0, 0, 1, 32'h0040_0022, 32'h1000_0002, 32'd5);
        vecs[21] = mk(1, 0, 32'd0,         0, 0, 0, 0, 32'd0,          0, 0, 1, 32'h0040_0022, 32'h1000_0002, 32'd5);
        vecs[22] = mk(0, 0, 32'd0,         0, 0, 0, 0, 32'd0,          0, 0, 0, 32'h0040_0000, 32'h0000_0000, 32'd0);
        vecs[23] = mk(0, 0, 32'd0,         0, 0, 0, 0, 32'd0,          1, 0, 0, 32'h0040_0000, 32'h0000_0000, 32'd0);

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req",   {31'd0, imem_req_o},    32'd0);
        chk("rst_addr",  imem_addr_o,            c_reset_pc);
        chk("rst_pc",    pc_o,                   c_reset_pc);
        chk("rst_pc4",   pc_plus4_o,             c_reset_pc + 32'd4);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o,                32'd0);
        chk("rst_opc",   {26'd0, opcode_o},      32'd0);
        chk("rst_fault", {31'd0, fault_o},       32'd0);
        chk("rst_cnt",   retired_count_o,        32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            reset           = vecs[i].rst;
            imem_ack_i      = vecs[i].ack;
            imem_rdata_i    = vecs[i].rdata;
            instr_ready_i   = vecs[i].rdy;
            branch_eq_i     = vecs[i].beq;
            branch_ne_i     = vecs[i].bne;
            zero_i          = vecs[i].z;
            branch_target_i = vecs[i].tgt;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req_o},    {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid_o}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_fault", i), {31'd0, fault_o},       {31'd0, vecs[i].e_fault});
            chk($sformatf("v%0d_addr", i),  imem_addr_o,            vecs[i].e_addr);
            chk($sformatf("v%0d_pc", i),    pc_o,                   vecs[i].e_addr);
            chk($sformatf("v%0d_pc4", i),   pc_plus4_o,             vecs[i].e_addr + 32'd4);
            chk($sformatf("v%0d_instr", i), instr_o,                vecs[i].e_instr);
            chk($sformatf("v%0d_opc", i),   {26'd0, opcode_o},      {26'd0, vecs[i].e_instr[31:26]});
            chk($sformatf("v%0d_cnt", i),   retired_count_o,        vecs[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // beq/bne resolution at 0x00400008
        branch_case("beq_taken",    1'b1, 1'b0, 1'b1, 32'h0040_0020);
        branch_case("beq_nottaken", 1'b1, 1'b0, 1'b0, 32'h0040_000C);
        branch_case("bne_taken",    1'b0, 1'b1, 1'b0, 32'h0040_0020);
        branch_case("bne_nottaken", 1'b0, 1'b1, 1'b1, 32'h0040_000C);

        // PC wrap from the top of the address space is not a fault
        do_reset();
        fetch_one("wrap_a", 32'h0040_0000, 32'h1000_0001, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pc4_top", pc_plus4_o, 32'h0000_0000);
        fetch_one("wrap_b", 32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap_addr",  imem_addr_o,            32'h0000_0000);
        chk("wrap_fault", {31'd0, fault_o},       32'd0);
        chk("wrap_req",   {31'd0, imem_req_o},    32'd1);
        chk("wrap_cnt",   retired_count_o,        32'd2);

        // Reset on the same edge as an ack discards the data
        do_reset();
        chk("rma_req_before", {31'd0, imem_req_o}, 32'd1);
        reset        = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h2008_0005;
        @(posedge clk);
        #1 reset = 1'b0;
        idle_inputs();
        chk("rma_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rma_instr", instr_o,                32'd0);
        chk("rma_req",   {31'd0, imem_req_o},    32'd0);
        chk("rma_addr",  imem_addr_o,            c_reset_pc);
        @(posedge clk);
        #1;
        chk("rma_refetch_req",  {31'd0, imem_req_o}, 32'd1);
        chk("rma_refetch_addr", imem_addr_o,         c_reset_pc);
        chk("rma_valid_after",  {31'd0, instr_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the single-issue MIPS core. It owns the program counter and issues one instruction-memory request at a time. It presents each fetched word, and its opcode field, to the control decoder. It then takes that instruction's branch_eq/branch_ne and ALU zero result back to choose the next PC.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000: PC loaded on reset; must be word aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_o  output  1  instruction-memory request valid.
- imem_addr_o  output  32  byte address of the request; equals pc_o.
- imem_ack_i  input  1  memory has returned data; sampled only while imem_req_o=1.
- imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
- instr_valid_o  output  1  instr_o/opcode_o hold a fetched instruction.
- instr_ready_i  input  1  decode/execute accepts the instruction this cycle.
- instr_o  output  32  fetched instruction word.
- opcode_o  output  6  instr_o[31:26], routed to the control decoder opcode input.
- pc_o  output  32  address of the current/pending instruction.
- pc_plus4_o  output  32  pc_o + 4, modulo 2^32.
- branch_eq_i  input  1  decoder branch-on-equal for the instruction on instr_o.
- branch_ne_i  input  1  decoder branch-on-not-equal for the instruction on instr_o.
- zero_i  input  1  ALU zero flag for the instruction on instr_o.
- branch_target_i  input  32  resolved branch target byte address.
- fault_o  output  1  sticky misaligned-target fault; fetch halted.
- retired_count_o  output  32  count of accepted instructions, wraps.

## Operation
- FSM states: RST, FETCH, HOLD, HALT.
- RST: the state while reset=1. On the first edge with reset=0, go to FETCH.
- FETCH:
  - imem_req_o=1.
  - imem_addr_o=pc_o, held stable until ack.
  - On imem_ack_i=1: capture imem_rdata_i into instr_o and go to HOLD.
- HOLD:
  - instr_valid_o=1 and imem_req_o=0.
  - On instr_ready_i=1 (accept): retired_count_o += 1 and pc_o <= next_pc.
  - If next_pc[1:0]!=0, go to HALT. Otherwise go to FETCH.
  - Without ready, hold all outputs unchanged.
- next_pc:
  - taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i).
  - next_pc = taken ? branch_target_i : pc_plus4_o.
  - There is no delay slot.
  - branch_* and zero_i are ignored outside the accept cycle.
- HALT:
  - fault_o=1, imem_req_o=0, instr_valid_o=0.
  - pc_o shows the faulting target.
  - Only reset leaves HALT.
- Exactly one outstanding request. imem_ack_i is ignored in RST, HOLD and HALT.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC+4 wraps to 0 with no fault.
- Reset values:
  - pc_o=imem_addr_o=RESET_PC, pc_plus4_o=RESET_PC+4.
  - imem_req_o=0, instr_valid_o=0, instr_o=0, opcode_o=0.
  - fault_o=0, retired_count_o=0.

## Timing
- Request: imem_req_o rises in the first cycle after reset deasserts, or in the cycle after an accept.
- Memory may ack in the same cycle req is first high (zero wait), or any number of cycles later.
- Ack at edge N gives instr_valid_o=1 in cycle N+1.
- Accept at edge M gives updated pc_o and imem_req_o=1 in cycle M+1.
- Peak throughput is one instruction per 2 cycles with zero-wait memory and ready tied high.
- Simultaneous ack and reset: reset wins; the data is discarded and instr_o=0.
- Reset in HOLD or HALT: all outputs return to reset values on that edge.
- retired_count_o updates on the same edge as pc_o. It wraps 32'hFFFF_FFFF -> 0.

## Test plan
- **Reset/first fetch:** hold reset 3 cycles, release, zero-wait memory returns 32'h2008_0005.
  - Required: cycle 1 after release shows req=1, addr=32'h0040_0000.
  - Next cycle: instr_valid_o=1, opcode_o=6'h08.
- **Sequential stream:** ready=1, zero-wait memory, 4 R-type words.
  - Required: addresses 0x00400000, 04, 08, 0C, each request 2 cycles apart.
  - retired_count_o=4 after the 4th accept.
- **Wait states and backpressure:** ack delayed 3 cycles; ready held low 5 cycles after valid.
  - Required: imem_addr_o stable throughout; instr_o and pc_o unchanged until ready.
  - Exactly one request per instruction.
- **Branches:** at pc 0x00400008 drive branch_eq_i=1 with target 0x00400020, once with zero_i=1 and once with zero_i=0; repeat with branch_ne_i.
  - Required: next addr 0x00400020 when taken, 0x0040000C when not taken.
- **Misaligned target:** taken branch to 0x00400022.
  - Required: HALT next cycle with fault_o=1, pc_o=0x00400022, no further req.
  - A later reset clears fault_o and refetches RESET_PC.
- **Reset mid-fetch:** assert reset in the same cycle as imem_ack_i.
  - Required: instr_valid_o stays 0, instr_o=0, and the fetch restarts at RESET_PC.
